// File: rtl/uart_rx_frontend.sv
// UART 8N1 receive front-end: pad synchroniser, 16x oversampler, frame FSM
// and a small first-word-fall-through receive FIFO with error flags.
module uart_rx_frontend #(
  parameter int OVS_DIV    = 27,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          rx_i,
  output logic [7:0]                    data_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          overrun_o,
  output logic                          frame_err_o,
  output logic                          break_o,
  input  logic                          clear_i
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic          r_sync1, r_sync2, r_rx_d;
  logic [15:0]   r_div;
  logic [3:0]    r_phase;
  state_t        r_state, w_state_n;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_wait_hi;
  logic          r_frame_err, r_break;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [LW-1:0] r_level;
  logic          r_overrun;

  logic w_rx_s, w_fall, w_tick, w_samp;
  logic w_push, w_ferr, w_pop, w_full, w_wr;

  assign w_rx_s = r_sync2;
  assign w_fall = r_rx_d & ~r_sync2;
  assign w_tick = (r_state != S_IDLE) && (r_div == 16'(OVS_DIV - 1));
  assign w_samp = w_tick && (r_phase == 4'd7);

  // Two-flop synchroniser plus a delayed copy for falling-edge detection.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_rx_d  <= 1'b1;
    end else begin
      r_sync1 <= rx_i;
      r_sync2 <= r_sync1;
      r_rx_d  <= r_sync2;
    end
  end

  // Oversample divider and 16-phase counter; both parked at 0 while idle so
  // every frame is timed from its own start edge.
  always_ff @(posedge clk_i) begin
    if (rst_i || r_state == S_IDLE) begin
      r_div   <= '0;
      r_phase <= '0;
    end else if (w_tick) begin
      r_div   <= '0;
      r_phase <= r_phase + 4'd1;
    end else begin
      r_div   <= r_div + 16'd1;
    end
  end

  // Frame state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_n;
  end

  // Next-state logic; stop-bit sample decides between push and frame error.
  always_comb begin
    w_state_n = r_state;
    w_push    = 1'b0;
    w_ferr    = 1'b0;
    unique case (r_state)
      S_IDLE:  if (!r_wait_hi && w_fall) w_state_n = S_START;
      S_START: if (w_samp) w_state_n = w_rx_s ? S_IDLE : S_DATA;
      S_DATA:  if (w_samp && r_bit == 3'd7) w_state_n = S_STOP;
      S_STOP: begin
        if (w_samp) begin
          w_state_n = S_IDLE;
          w_push    = w_rx_s;
          w_ferr    = ~w_rx_s;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  // Data shifter, bit index, error pulses and the re-arm guard that keeps a
  // held break from re-triggering start detection.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_bit       <= '0;
      r_shift     <= '0;
      r_wait_hi   <= 1'b0;
      r_frame_err <= 1'b0;
      r_break     <= 1'b0;
    end else begin
      r_frame_err <= w_ferr;
      r_break     <= w_ferr && (r_shift == 8'h00);
      if (r_state == S_START && w_samp) r_bit <= '0;
      if (r_state == S_DATA && w_samp) begin
        r_shift <= {w_rx_s, r_shift[7:1]};
        r_bit   <= r_bit + 3'd1;
      end
      if (w_ferr)                            r_wait_hi <= 1'b1;
      else if (r_state == S_IDLE && w_rx_s)  r_wait_hi <= 1'b0;
    end
  end

  assign w_pop  = valid_o & ready_i;
  assign w_full = (r_level == LW'(FIFO_DEPTH));
  assign w_wr   = w_push && (!w_full || w_pop);

  // FIFO storage; contents need no reset since the level gates data_o.
  always_ff @(posedge clk_i) begin
    if (w_wr) r_mem[r_wr] <= r_shift;
  end

  // FIFO pointers, occupancy and sticky overrun (clear wins over set).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr      <= '0;
      r_rd      <= '0;
      r_level   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_wr)  r_wr <= r_wr + AW'(1);
      if (w_pop) r_rd <= r_rd + AW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
      if (clear_i)              r_overrun <= 1'b0;
      else if (w_push && !w_wr) r_overrun <= 1'b1;
    end
  end

  assign valid_o      = (r_level != '0);
  assign data_o       = valid_o ? r_mem[r_rd] : 8'h00;
  assign fifo_level_o = r_level;
  assign overrun_o    = r_overrun;
  assign frame_err_o  = r_frame_err;
  assign break_o      = r_break;

endmodule

// File: doc/uart_rx_frontend.md
Name: uart_rx_frontend

Overview:
- UART receive front-end that feeds the SoC's byte-oriented receive path from the raw `io_in[35]` pad signal.
- Synchronises the asynchronous pad input, oversamples at 16x, and frames 8N1 characters.
- Buffers received bytes in a small FWFT FIFO exposed as a valid/ready stream, with error flags for overrun, framing error and break.
- Sits between the pad mux and the SoC UART consumer, in the same clock domain as the SoC.

Parameters:
- OVS_DIV, 27, clk_i cycles per oversample tick (bit period = 16*OVS_DIV clocks); legal range 2..65535.
- FIFO_DEPTH, 8, receive FIFO entries; power of two, minimum 2.

Ports:
- clk_i  input  1  block clock, same as SoC clock.
- rst_i  input  1  synchronous, active-high reset.
- rx_i  input  1  raw asynchronous serial input from pad; idle high.
- data_o  output  8  head-of-FIFO byte; valid only while valid_o=1.
- valid_o  output  1  FIFO non-empty.
- ready_i  input  1  consumer accepts; pop occurs on valid_o & ready_i.
- fifo_level_o  output  $clog2(FIFO_DEPTH)+1  current occupancy.
- overrun_o  output  1  sticky: byte dropped because the FIFO was full.
- frame_err_o  output  1  one-cycle pulse: stop bit sampled low.
- break_o  output  1  one-cycle pulse: frame error with all data bits 0.
- clear_i  input  1  clears overrun_o; has priority over a same-cycle set.

Behaviour:
- Reset (rst_i=1 at a clk_i edge):
  - synchroniser flops = 1; FSM = IDLE; counters = 0; FIFO emptied.
  - valid_o=0, fifo_level_o=0, overrun_o=0, frame_err_o=0, break_o=0, data_o=0.
  - Reset mid-frame abandons the frame; nothing is pushed.
- Synchroniser:
  - 2-flop chain; rx_s = second flop.
  - Falling-edge detection uses rx_s and a third registered copy.
- Oversample tick:
  - Divider counts 0..OVS_DIV-1; tick pulses when the divider = OVS_DIV-1.
  - Divider is held at 0 in IDLE and starts counting from 0 the cycle after start detection.
  - Phase counter counts 0..15 on ticks; sample point is the tick where phase=7.
- FSM:
  - IDLE: on a falling edge of rx_s -> START.
  - START: at the sample point, rx_s=1 -> IDLE (glitch, no flags); rx_s=0 -> DATA with bit index 0.
  - DATA: at each sample point, shift rx_s in LSB first; after bit index 7 -> STOP.
  - STOP, sample rx_s=1: push the byte.
  - STOP, sample rx_s=0: pulse frame_err_o and drop the byte. If the byte is 0x00, also pulse break_o.
  - After the STOP sample: -> IDLE immediately (mid-stop-bit), so back-to-back frames are received.
  - After a frame error the FSM waits in IDLE for rx_s=1 before re-arming start detection, so a held break produces one event only.
- FIFO:
  - Circular buffer; pointers are $clog2(FIFO_DEPTH) bits and wrap naturally; level counter tracks occupancy.
  - Push is accepted if level<FIFO_DEPTH, or if level=FIFO_DEPTH and a pop occurs in the same cycle.
  - Otherwise the byte is dropped and overrun_o sets in the next cycle.
  - Simultaneous push and pop: level unchanged.
  - Pop when empty is ignored.
  - data_o/valid_o are FWFT: valid_o rises the cycle after the push clock edge.
- Latency: from the stop-bit sample point to valid_o=1 is 1 clk_i cycle (FIFO previously empty).
- frame_err_o and break_o are asserted for exactly 1 cycle, in the cycle after the STOP sample.

Test Plan:
- OVS_DIV=4 (bit period 64 clocks): send 0xA5 8N1 -> valid_o=1 with data_o=0xA5 one cycle after the stop sample; fifo_level_o=1; no flags.
- Low glitch of 20 clocks on rx_i (shorter than half a bit) -> FSM returns to IDLE, FIFO unchanged, no flags.
- Send 9 bytes 0x01..0x09 with ready_i=0, FIFO_DEPTH=8 -> level=8, overrun_o=1, FIFO holds 0x01..0x08; pulse clear_i -> overrun_o=0.
- Byte 0x3C with stop bit forced 0 -> frame_err_o pulses once, break_o=0, nothing pushed. Then hold rx_i low for 20 bit periods -> exactly one frame_err_o and one break_o pulse, after which a following valid byte is received normally.
- FIFO full, with ready_i=1 in the same cycle as a new push -> head popped, new byte stored, level stays 8, overrun_o stays 0.
- Assert rst_i mid-DATA of byte 0x55, then send 0x12 -> only 0x12 appears; all outputs read their reset values during reset.
